// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared receiver state encoding, parity codes, error bits
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] c_PAR_NONE     = 2'b00;
  localparam logic [1:0] c_PAR_ODD      = 2'b01;
  localparam logic [1:0] c_PAR_EVEN     = 2'b10;
  localparam logic [1:0] c_PAR_NONE_ALT = 2'b11;

  localparam int c_ERR_PARITY = 0;
  localparam int c_ERR_START  = 1;
  localparam int c_ERR_STOP   = 2;

  function automatic logic parity_enabled(input logic [1:0] pt);
    return !((pt == c_PAR_NONE) || (pt == c_PAR_NONE_ALT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_sync : two-flop synchronizer for the idle-high serial line
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_ctrl : oversampling UART receiver with parity/start/stop checks
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [2:0]           error_flag,
  output logic                 done,
  output logic                 busy
);

  localparam int c_TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int c_BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

  logic                 w_rx;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [c_TICK_W-1:0]  r_tick;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_par_type;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_rx_data;
  logic [2:0]           r_err;
  logic                 r_done;
  logic                 w_tick_last;
  logic                 w_result;
  logic [2:0]           w_err_nxt;

  uart_rx_sync u_sync (
    .clk     (clock),
    .rst     (reset),
    .i_async (rx_in),
    .o_sync  (w_rx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_result    = 1'b0;
    w_err_nxt   = '0;
    w_tick_last = baud_tick && (r_tick == c_TICK_LAST);
    case (r_state)
      ST_IDLE: begin
        if (baud_tick && !w_rx) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (baud_tick && (r_tick == c_TICK_MID)) begin
          if (w_rx) begin
            w_state_nxt            = ST_IDLE;
            w_result               = 1'b1;
            w_err_nxt[c_ERR_START] = 1'b1;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_tick_last && (r_bit_cnt == c_BIT_LAST))
          w_state_nxt = parity_enabled(r_par_type) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_tick_last) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick_last) begin
          w_state_nxt             = ST_IDLE;
          w_result                = 1'b1;
          w_err_nxt[c_ERR_STOP]   = ~w_rx;
          w_err_nxt[c_ERR_PARITY] = r_par_err;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick     <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_type <= c_PAR_NONE;
      r_par_err  <= 1'b0;
      r_rx_data  <= '0;
      r_err      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_result;

      // Counter restarts on any state change so every phase measures from its own entry.
      if (w_state_nxt != r_state) begin
        r_tick <= '0;
      end else if (baud_tick && (r_state != ST_IDLE)) begin
        r_tick <= (r_tick == c_TICK_LAST) ? '0 : r_tick + 1'b1;
      end

      if ((r_state == ST_IDLE) && (w_state_nxt == ST_START)) begin
        r_par_type <= parity_type;
        r_par_err  <= 1'b0;
        r_bit_cnt  <= '0;
      end

      if ((r_state == ST_DATA) && w_tick_last) begin
        r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if ((r_state == ST_PARITY) && w_tick_last) begin
        r_par_err <= (r_par_type == c_PAR_ODD) ? ~(^r_shift ^ w_rx) : (^r_shift ^ w_rx);
      end

      if (w_result) begin
        r_err <= w_err_nxt;
        if (r_state == ST_STOP) r_rx_data <= r_shift;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign error_flag = r_err;
  assign done       = r_done;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx_ctrl : scoreboard bench for the UART receiver
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int c_OS       = 16;
  localparam int c_DW       = 8;
  localparam int c_TICK_DIV = 4;
  localparam int c_BIT_CLKS = c_OS * c_TICK_DIV;

  logic            clock = 1'b0;
  logic            reset;
  logic            baud_tick;
  logic            rx_in;
  logic            tick_en;
  logic [1:0]      parity_type;
  logic [c_DW-1:0] rx_data;
  logic [2:0]      error_flag;
  logic            done;
  logic            busy;

  typedef struct {
    logic [7:0] data;
    logic [2:0] err;
    logic       busy;
  } res_t;

  res_t       exp_q[$];
  res_t       obs_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_data;

  uart_rx_ctrl #(.OVERSAMPLE(c_OS), .DATA_BITS(c_DW)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .rx_in       (rx_in),
    .parity_type (parity_type),
    .rx_data     (rx_data),
    .error_flag  (error_flag),
    .done        (done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (c_TICK_DIV - 1) @(negedge clock);
      baud_tick = tick_en;
      @(negedge clock);
      baud_tick = 1'b0;
    end
  end

  // every done-high cycle is recorded, so a stretched pulse shows up as an extra result
  always @(negedge clock) begin
    res_t r;
    if (done === 1'b1) begin
      r.data = rx_data;
      r.err  = error_flag;
      r.busy = busy;
      obs_q.push_back(r);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] pt_mid,
                            input logic pbit, input logic stopb);
    res_t e;
    logic perr;
    perr = 1'b0;
    if (pt == 2'b01) perr = ~(^d ^ pbit);
    else if (pt == 2'b10) perr = ^d ^ pbit;
    e.data = d;
    e.err  = {~stopb, 1'b0, perr};
    e.busy = 1'b0;
    exp_q.push_back(e);
    last_data   = d;
    parity_type = pt;
    rx_in = 1'b0;
    repeat (c_BIT_CLKS) @(negedge clock);
    parity_type = pt_mid;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (c_BIT_CLKS) @(negedge clock);
    end
    if (pt == 2'b01 || pt == 2'b10) begin
      rx_in = pbit;
      repeat (c_BIT_CLKS) @(negedge clock);
    end
    rx_in = stopb;
    repeat (c_BIT_CLKS) @(negedge clock);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    last_data = 8'h00;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (error_flag !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b expected 000", error_flag); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_no_parity;
    res_t o, e;
    send_frame(8'hA5, 2'b00, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 400 && obs_q.size() < 1; k++) @(negedge clock);
    repeat (4) @(negedge clock);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL nopar_count: got %0d done pulses expected 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL nopar_data: got %h expected %h", o.data, e.data); end
      n_checks++; if (o.err !== e.err) begin n_fail++; $display("FAIL nopar_err: got %b expected %b", o.err, e.err); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_odd_parity;
    res_t o, e;
    send_frame(8'h01, 2'b01, 2'b01, 1'b0, 1'b1);
    // parity_type changed after the start bit must not affect the frame
    send_frame(8'h01, 2'b01, 2'b10, 1'b1, 1'b1);
    for (int k = 0; k < 400 && obs_q.size() < 2; k++) @(negedge clock);
    repeat (4) @(negedge clock);
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL odd_count: got %0d done pulses expected 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL odd_data: got %h expected %h", o.data, e.data); end
      n_checks++; if (o.err !== e.err) begin n_fail++; $display("FAIL odd_err: got %b expected %b", o.err, e.err); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch;
    res_t o, e;
    e.data = last_data; e.err = 3'b010; e.busy = 1'b0;
    exp_q.push_back(e);
    rx_in = 1'b0;
    repeat (4 * c_TICK_DIV) @(negedge clock);
    rx_in = 1'b1;
    for (int k = 0; k < 400 && obs_q.size() < 1; k++) @(negedge clock);
    repeat (4) @(negedge clock);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL glitch_count: got %0d done pulses expected 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", o.data, e.data); end
      n_checks++; if (o.err !== e.err) begin n_fail++; $display("FAIL glitch_err: got %b expected %b", o.err, e.err); end
      n_checks++; if (o.busy !== e.busy) begin n_fail++; $display("FAIL glitch_busy: got %b expected %b", o.busy, e.busy); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy got %b expected 0", busy); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_even_stop_err;
    res_t o, e;
    send_frame(8'h3C, 2'b10, 2'b10, 1'b0, 1'b0);
    // the low stop bit would be taken as a new start; clear it before it matures
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    last_data = 8'h00;
    repeat (4) @(negedge clock);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL stop_count: got %0d done pulses expected 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL stop_data: got %h expected %h", o.data, e.data); end
      n_checks++; if (o.err !== e.err) begin n_fail++; $display("FAIL stop_err: got %b expected %b", o.err, e.err); end
      n_checks++; if (o.busy !== e.busy) begin n_fail++; $display("FAIL stop_busy: got %b expected %b", o.busy, e.busy); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    res_t o, e;
    logic [7:0] d;
    d = 8'h55;
    parity_type = 2'b00;
    rx_in = 1'b0;
    repeat (c_BIT_CLKS) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      repeat (c_BIT_CLKS) @(negedge clock);
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rx_in = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    last_data = 8'h00;
    repeat (2 * c_BIT_CLKS) @(negedge clock);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_nodone: got %0d done pulses expected 0", obs_q.size()); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
    n_checks++; if (error_flag !== 3'b000) begin n_fail++; $display("FAIL midrst_err: got %b expected 000", error_flag); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    obs_q.delete();
    send_frame(8'hFF, 2'b00, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 400 && obs_q.size() < 1; k++) @(negedge clock);
    repeat (4) @(negedge clock);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL ff_count: got %0d done pulses expected 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL ff_data: got %h expected %h", o.data, e.data); end
      n_checks++; if (o.err !== e.err) begin n_fail++; $display("FAIL ff_err: got %b expected %b", o.err, e.err); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    res_t o, e;
    send_frame(8'h12, 2'b00, 2'b00, 1'b0, 1'b1);
    send_frame(8'h34, 2'b00, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 400 && obs_q.size() < 2; k++) @(negedge clock);
    repeat (4) @(negedge clock);
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d done pulses expected 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", o.data, e.data); end
      n_checks++; if (o.err !== e.err) begin n_fail++; $display("FAIL b2b_err: got %b expected %b", o.err, e.err); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_no_tick;
    tick_en = 1'b0;
    rx_in   = 1'b0;
    repeat (3 * c_BIT_CLKS) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL notick_busy: got %b expected 0", busy); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL notick_done: got %0d done pulses expected 0", obs_q.size()); end
    rx_in = 1'b1;
    repeat (4) @(negedge clock);
    tick_en = 1'b1;
    repeat (c_BIT_CLKS) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL notick_resume: busy got %b expected 0", busy); end
    obs_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    rx_in       = 1'b1;
    tick_en     = 1'b1;
    parity_type = 2'b00;
    last_data   = 8'h00;
    repeat (2) @(negedge clock);
    test_reset;
    test_no_parity;
    test_odd_parity;
    test_glitch;
    test_even_stop_err;
    test_reset_mid_frame;
    test_back_to_back;
    test_no_tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: baud_tick pulses per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame.
REQ-003 SHALL have ports, clock and reset first:
  clock        in   1          single clock; all state on rising edge
  reset        in   1          synchronous, active-high reset
  baud_tick    in   1          one-cycle enable at OVERSAMPLE x baud rate
  rx_in        in   1          asynchronous serial line, idle high
  parity_type  in   2          00/11 none, 01 odd, 10 even
  rx_data      out  DATA_BITS  last received word, LSB first on the line
  error_flag   out  3          [0] parity, [1] start, [2] stop error
  done         out  1          one-clock pulse when a frame result is valid
  busy         out  1          high in every state except IDLE
REQ-004 SHALL be clocked by one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 SHALL pass rx_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-006 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-007 SHALL keep a tick counter 0..OVERSAMPLE-1 that advances only on baud_tick and clears on every state entry.
REQ-008 In IDLE, on baud_tick with synchronized rx low, SHALL enter START.
REQ-009 In START, at tick count OVERSAMPLE/2-1: rx low -> enter DATA; rx high -> set error_flag=3'b010, pulse done, return to IDLE, leaving rx_data unchanged.
REQ-010 In DATA, SHALL sample one bit per OVERSAMPLE ticks at count OVERSAMPLE-1, shift it in LSB first, and leave after DATA_BITS samples.
REQ-011 After DATA, SHALL enter PARITY if parity_type is 01 or 10, else STOP.
REQ-012 In PARITY, SHALL sample one bit; odd: error if ones(data)+parity is even; even: error if ones(data)+parity is odd.
REQ-013 In STOP, SHALL sample one bit at count OVERSAMPLE-1; sampled 0 -> stop error.
REQ-014 On the STOP sample cycle, SHALL register rx_data and error_flag ({stop,0,parity}) and pulse done the next clock for exactly one cycle.
REQ-015 rx_data and error_flag SHALL hold between done pulses.
REQ-016 After STOP, SHALL return to IDLE and SHALL accept a new start bit on the next baud_tick.
REQ-017 SHALL sample parity_type on entry to START; changes mid-frame SHALL not affect that frame.
REQ-018 With parity none, error_flag[0] SHALL be 0.
REQ-019 Without baud_tick, no state or counter SHALL advance.

Reset
REQ-020 On reset, SHALL set state IDLE, counters 0, rx_data 0, error_flag 0, done 0, busy 0, and both synchronizer flops to 1.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-022 Reset SHALL take priority over baud_tick.

Structure
REQ-023 State encoding, parity_type codes, and error_flag bit positions SHALL live in shared package uart_pkg.
REQ-024 The synchronizer SHALL be the sub-module uart_rx_sync; the rest SHALL be flat.

Verification
REQ-025 Frame 0xA5, parity none, stop 1 -> one done pulse, rx_data=8'hA5, error_flag=3'b000.
REQ-026 Frame 0x01, odd parity, parity bit 0 -> rx_data=8'h01, error_flag=3'b000; parity bit 1 -> error_flag=3'b001.
REQ-027 Frame 0x3C, even parity, stop bit 0 -> rx_data=8'h3C, error_flag=3'b100.
REQ-028 rx low for 4 ticks then high (glitch) -> done pulse, error_flag=3'b010, rx_data unchanged, busy drops.
REQ-029 Reset asserted during DATA of 0x55 -> no done pulse, outputs 0, then clean frame 0xFF -> rx_data=8'hFF, error_flag=3'b000.
REQ-030 Back-to-back frames 0x12 then 0x34 with no idle gap -> two done pulses, 8'h12 then 8'h34.
